// File: rtl/rs_issue_select_pkg.sv
// Shared constants and per-entry status for the reservation-station issue side.
package rs_issue_select_pkg;
  localparam int ENTRY_SEL = 2;
  localparam int ENTRY_NUM = 1 << ENTRY_SEL;
  localparam int TAG_LEN   = 6;

  typedef logic [TAG_LEN-1:0]   tag_t;
  typedef logic [ENTRY_SEL-1:0] idx_t;

  typedef struct packed {
    logic busy;
    logic issuing;
    logic src1_rdy;
    logic src2_rdy;
    tag_t src1_tag;
    tag_t src2_tag;
  } rs_entry_t;

  function automatic rs_entry_t new_entry(input tag_t t1, input tag_t t2,
                                          input logic r1, input logic r2);
    rs_entry_t e;
    e.busy     = 1'b1;
    e.issuing  = 1'b0;
    e.src1_rdy = r1;
    e.src2_rdy = r2;
    e.src1_tag = t1;
    e.src2_tag = t2;
    return e;
  endfunction
endpackage

// File: rtl/rs_issue_select_if.sv
// Allocation, writeback-broadcast and issue handshake bundle of the issue selector.
interface rs_issue_select_if;
  import rs_issue_select_pkg::*;

  logic                 alloc_we1_i;
  idx_t                 alloc_entry1_i;
  tag_t                 alloc_src1_tag1_i;
  tag_t                 alloc_src2_tag1_i;
  logic                 alloc_src1_rdy1_i;
  logic                 alloc_src2_rdy1_i;
  logic                 alloc_we2_i;
  idx_t                 alloc_entry2_i;
  tag_t                 alloc_src1_tag2_i;
  tag_t                 alloc_src2_tag2_i;
  logic                 alloc_src1_rdy2_i;
  logic                 alloc_src2_rdy2_i;
  logic                 wb_valid1_i;
  tag_t                 wb_tag1_i;
  logic                 wb_valid2_i;
  tag_t                 wb_tag2_i;
  logic [ENTRY_NUM-1:0] busy_o;
  logic                 issue_valid_o;
  logic                 issue_ready_i;
  idx_t                 issue_entry_o;

  modport master (
    output alloc_we1_i, alloc_entry1_i, alloc_src1_tag1_i, alloc_src2_tag1_i,
           alloc_src1_rdy1_i, alloc_src2_rdy1_i,
           alloc_we2_i, alloc_entry2_i, alloc_src1_tag2_i, alloc_src2_tag2_i,
           alloc_src1_rdy2_i, alloc_src2_rdy2_i,
           wb_valid1_i, wb_tag1_i, wb_valid2_i, wb_tag2_i, issue_ready_i,
    input  busy_o, issue_valid_o, issue_entry_o
  );

  modport slave (
    input  alloc_we1_i, alloc_entry1_i, alloc_src1_tag1_i, alloc_src2_tag1_i,
           alloc_src1_rdy1_i, alloc_src2_rdy1_i,
           alloc_we2_i, alloc_entry2_i, alloc_src1_tag2_i, alloc_src2_tag2_i,
           alloc_src1_rdy2_i, alloc_src2_rdy2_i,
           wb_valid1_i, wb_tag1_i, wb_valid2_i, wb_tag2_i, issue_ready_i,
    output busy_o, issue_valid_o, issue_entry_o
  );
endinterface

// File: rtl/rs_issue_select_wakeup_cmp.sv
// Source-operand wakeup: exact tag match against either valid writeback broadcast.
module rs_wakeup_cmp
  import rs_issue_select_pkg::*;
(
  input  tag_t tag_i,
  input  logic wb_valid1_i,
  input  tag_t wb_tag1_i,
  input  logic wb_valid2_i,
  input  tag_t wb_tag2_i,
  output logic wake_o
);
  assign wake_o = (wb_valid1_i && (tag_i == wb_tag1_i)) ||
                  (wb_valid2_i && (tag_i == wb_tag2_i));
endmodule

// File: rtl/rs_issue_select.sv
// Reservation-station issue selector: tracks busy/ready state, wakes operands on
// writeback broadcasts and issues the lowest-index ready entry per cycle.
module rs_issue_select
  import rs_issue_select_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  rs_issue_select_if.slave   bus
);
  rs_entry_t [ENTRY_NUM-1:0] ent_q, ent_d;
  logic                      issue_valid_q, issue_valid_d;
  idx_t                      issue_entry_q, issue_entry_d;

  logic [ENTRY_NUM-1:0] wake1, wake2, elig;
  logic                 a1_w1, a1_w2, a2_w1, a2_w2;
  logic                 any_elig, fire, load;
  idx_t                 sel;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    rs_wakeup_cmp u_src1 (
      .tag_i(ent_q[i].src1_tag), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
      .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(wake1[i])
    );
    rs_wakeup_cmp u_src2 (
      .tag_i(ent_q[i].src2_tag), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
      .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(wake2[i])
    );
    assign elig[i]       = ent_q[i].busy && ent_q[i].src1_rdy && ent_q[i].src2_rdy &&
                           !ent_q[i].issuing;
    assign bus.busy_o[i] = ent_q[i].busy;
  end

  // Same-cycle bypass: an operand produced while it is being allocated must not be missed.
  rs_wakeup_cmp u_a1s1 (
    .tag_i(bus.alloc_src1_tag1_i), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
    .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(a1_w1)
  );
  rs_wakeup_cmp u_a1s2 (
    .tag_i(bus.alloc_src2_tag1_i), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
    .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(a1_w2)
  );
  rs_wakeup_cmp u_a2s1 (
    .tag_i(bus.alloc_src1_tag2_i), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
    .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(a2_w1)
  );
  rs_wakeup_cmp u_a2s2 (
    .tag_i(bus.alloc_src2_tag2_i), .wb_valid1_i(bus.wb_valid1_i), .wb_tag1_i(bus.wb_tag1_i),
    .wb_valid2_i(bus.wb_valid2_i), .wb_tag2_i(bus.wb_tag2_i), .wake_o(a2_w2)
  );

  always_comb begin
    sel      = '0;
    any_elig = |elig;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (elig[i]) sel = idx_t'(i);
    end
  end

  assign fire = issue_valid_q && bus.issue_ready_i;
  assign load = !issue_valid_q || bus.issue_ready_i;

  always_comb begin
    ent_d         = ent_q;
    issue_valid_d = issue_valid_q;
    issue_entry_d = issue_entry_q;
    if (flush_i) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ent_d[i].busy     = 1'b0;
        ent_d[i].issuing  = 1'b0;
        ent_d[i].src1_rdy = 1'b0;
        ent_d[i].src2_rdy = 1'b0;
      end
      issue_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (ent_q[i].busy) begin
          ent_d[i].src1_rdy = ent_q[i].src1_rdy | wake1[i];
          ent_d[i].src2_rdy = ent_q[i].src2_rdy | wake2[i];
        end
      end
      if (fire) begin
        ent_d[issue_entry_q].busy    = 1'b0;
        ent_d[issue_entry_q].issuing = 1'b0;
      end
      // The chosen entry is marked issuing so the next selection skips it.
      if (load) begin
        issue_valid_d = any_elig;
        issue_entry_d = sel;
        if (any_elig) ent_d[sel].issuing = 1'b1;
      end
      if (bus.alloc_we1_i) begin
        ent_d[bus.alloc_entry1_i] = new_entry(bus.alloc_src1_tag1_i, bus.alloc_src2_tag1_i,
                                              bus.alloc_src1_rdy1_i | a1_w1,
                                              bus.alloc_src2_rdy1_i | a1_w2);
      end
      if (bus.alloc_we2_i) begin
        ent_d[bus.alloc_entry2_i] = new_entry(bus.alloc_src1_tag2_i, bus.alloc_src2_tag2_i,
                                              bus.alloc_src1_rdy2_i | a2_w1,
                                              bus.alloc_src2_rdy2_i | a2_w2);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ent_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_entry_q <= '0;
    end else begin
      ent_q         <= ent_d;
      issue_valid_q <= issue_valid_d;
      issue_entry_q <= issue_entry_d;
    end
  end

  assign bus.issue_valid_o = issue_valid_q;
  assign bus.issue_entry_o = issue_entry_q;

  // Allocator contract; a flush discards the allocation, so it is exempt.
  always @(posedge clk_i) begin
    if (rst_n_i && !flush_i) begin
      assert (!(bus.alloc_we1_i && ent_q[bus.alloc_entry1_i].busy));
      assert (!(bus.alloc_we2_i && ent_q[bus.alloc_entry2_i].busy));
      assert (!(bus.alloc_we1_i && bus.alloc_we2_i &&
                (bus.alloc_entry1_i == bus.alloc_entry2_i)));
    end
  end
endmodule

// File: tb/tb_rs_issue_select.sv
// Randomized and directed bench for rs_issue_select with a queue-based scoreboard.
module tb_rs_issue_select;
  logic clk;
  logic rst_n;
  logic flush;

  rs_issue_select_if bus ();

  rs_issue_select dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit flush;
    bit we1; int e1; int t11; int t21; bit r11; bit r21;
    bit we2; int e2; int t12; int t22; bit r12; bit r22;
    bit wv1; int wt1; bit wv2; int wt2;
    bit rdy;
  } stim_t;

  typedef struct {
    logic [3:0] busy;
    bit         v;
    int         e;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference: per-entry bookkeeping plus the presented issue slot.
  bit m_busy[4], m_iss[4], m_r1[4], m_r2[4];
  int m_t1[4], m_t2[4];
  bit m_v;
  int m_e;

  function automatic bit produced(int tag, stim_t s);
    return (s.wv1 && tag == s.wt1) || (s.wv2 && tag == s.wt2);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
    end
    m_v = 0;
  endfunction

  function automatic void model_step(stim_t s);
    int ready_list[$];
    if (s.flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 4; i++)
      if (m_busy[i] && m_r1[i] && m_r2[i] && !m_iss[i]) ready_list.push_back(i);
    for (int i = 0; i < 4; i++) begin
      if (m_busy[i]) begin
        if (produced(m_t1[i], s)) m_r1[i] = 1;
        if (produced(m_t2[i], s)) m_r2[i] = 1;
      end
    end
    if (m_v && s.rdy) begin
      m_busy[m_e] = 0;
      m_iss[m_e]  = 0;
    end
    if (!m_v || s.rdy) begin
      m_v = (ready_list.size() > 0);
      if (m_v) begin
        m_e = ready_list[0];
        m_iss[m_e] = 1;
      end
    end
    if (s.we1) begin
      m_busy[s.e1] = 1; m_iss[s.e1] = 0; m_t1[s.e1] = s.t11; m_t2[s.e1] = s.t21;
      m_r1[s.e1] = s.r11 || produced(s.t11, s);
      m_r2[s.e1] = s.r21 || produced(s.t21, s);
    end
    if (s.we2) begin
      m_busy[s.e2] = 1; m_iss[s.e2] = 0; m_t1[s.e2] = s.t12; m_t2[s.e2] = s.t22;
      m_r1[s.e2] = s.r12 || produced(s.t12, s);
      m_r2[s.e2] = s.r22 || produced(s.t22, s);
    end
  endfunction

  task automatic drive(stim_t s);
    flush                 = s.flush;
    bus.alloc_we1_i       = s.we1;
    bus.alloc_entry1_i    = 2'(s.e1);
    bus.alloc_src1_tag1_i = 6'(s.t11);
    bus.alloc_src2_tag1_i = 6'(s.t21);
    bus.alloc_src1_rdy1_i = s.r11;
    bus.alloc_src2_rdy1_i = s.r21;
    bus.alloc_we2_i       = s.we2;
    bus.alloc_entry2_i    = 2'(s.e2);
    bus.alloc_src1_tag2_i = 6'(s.t12);
    bus.alloc_src2_tag2_i = 6'(s.t22);
    bus.alloc_src1_rdy2_i = s.r12;
    bus.alloc_src2_rdy2_i = s.r22;
    bus.wb_valid1_i       = s.wv1;
    bus.wb_tag1_i         = 6'(s.wt1);
    bus.wb_valid2_i       = s.wv2;
    bus.wb_tag2_i         = 6'(s.wt2);
    bus.issue_ready_i     = s.rdy;
  endtask

  task automatic cycle(stim_t s);
    exp_t x;
    @(negedge clk);
    drive(s);
    model_step(s);
    for (int i = 0; i < 4; i++) x.busy[i] = m_busy[i];
    x.v = m_v;
    x.e = m_e;
    expq.push_back(x);
  endtask

  function automatic stim_t idle(bit rdy);
    stim_t s;
    s = '{default: 0};
    s.rdy = rdy;
    return s;
  endfunction

  task automatic drain();
    repeat (6) cycle(idle(1));
  endtask

  task automatic check_zero(string tag);
    tests++;
    if (bus.busy_o !== 4'b0 || bus.issue_valid_o !== 1'b0 || bus.issue_entry_o !== 2'b0) begin
      fails++;
      $display("FAIL %s: busy=%b valid=%b entry=%0d, required all zero",
               tag, bus.busy_o, bus.issue_valid_o, bus.issue_entry_o);
    end
  endtask

  // Monitor: compares the DUT against the next queued expectation after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        tests++;
        if (bus.busy_o !== x.busy) begin
          fails++;
          $display("FAIL busy cyc%0d: got %b, required %b", cyc, bus.busy_o, x.busy);
        end
        tests++;
        if (bus.issue_valid_o !== x.v) begin
          fails++;
          $display("FAIL issue_valid cyc%0d: got %b, required %b", cyc, bus.issue_valid_o, x.v);
        end
        if (x.v) begin
          tests++;
          if (int'(bus.issue_entry_o) != x.e) begin
            fails++;
            $display("FAIL issue_entry cyc%0d: got %0d, required %0d",
                     cyc, bus.issue_entry_o, x.e);
          end
        end
      end
    end
  end

  function automatic int rtag();
    return ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    stim_t s;
    int    freeq[$];
    int    k;
    rst_n = 1'b0;
    drive(idle(0));
    model_clear();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ready allocation, issue two edges later, accepted
    s = idle(0); s.we1 = 1; s.e1 = 0; s.r11 = 1; s.r21 = 1;
    cycle(s);
    cycle(idle(1)); cycle(idle(1)); cycle(idle(1));

    // 2: two allocations waiting on tag 5, woken together
    s = idle(1); s.we1 = 1; s.e1 = 1; s.t11 = 5; s.r21 = 1;
    s.we2 = 1; s.e2 = 2; s.t12 = 5; s.r22 = 1;
    cycle(s);
    cycle(idle(1));
    s = idle(1); s.wv1 = 1; s.wt1 = 5;
    cycle(s);
    drain();

    // 3: allocation bypass from broadcast port 2 via slot 1
    s = idle(1); s.we1 = 1; s.e1 = 3; s.r11 = 1; s.t21 = 9; s.wv2 = 1; s.wt2 = 9;
    cycle(s);
    drain();

    // 4: stall holds entry 0, then back-to-back issue
    s = idle(0); s.we1 = 1; s.e1 = 0; s.r11 = 1; s.r21 = 1;
    s.we2 = 1; s.e2 = 1; s.r12 = 1; s.r22 = 1;
    cycle(s);
    repeat (4) cycle(idle(0));
    drain();

    // 5: full station, flush beats handshake and allocation
    s = idle(0); s.we1 = 1; s.e1 = 0; s.r11 = 1; s.r21 = 1;
    s.we2 = 1; s.e2 = 1; s.r12 = 1; s.r22 = 1;
    cycle(s);
    s.e1 = 2; s.e2 = 3;
    cycle(s);
    cycle(idle(0));
    s = idle(1); s.flush = 1; s.we1 = 1; s.e1 = 0; s.r11 = 1; s.r21 = 1;
    cycle(s);
    cycle(idle(1));

    // 6: asynchronous reset during a stall
    s = idle(0); s.we1 = 1; s.e1 = 0; s.r11 = 1; s.r21 = 1;
    s.we2 = 1; s.e2 = 1; s.r12 = 1; s.r22 = 1;
    cycle(s);
    repeat (3) cycle(idle(0));
    @(negedge clk);
    drive(idle(0));
    #2;
    rst_n = 1'b0;
    expq.delete();
    model_clear();
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      s = idle($urandom_range(0, 9) < 6);
      freeq.delete();
      for (int i = 0; i < 4; i++) if (!m_busy[i]) freeq.push_back(i);
      if (freeq.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, freeq.size() - 1);
        s.we1 = 1; s.e1 = freeq[k]; freeq.delete(k);
        s.t11 = rtag(); s.t21 = rtag(); s.r11 = $urandom_range(0, 1); s.r21 = $urandom_range(0, 1);
      end
      if (freeq.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, freeq.size() - 1);
        s.we2 = 1; s.e2 = freeq[k];
        s.t12 = rtag(); s.t22 = rtag(); s.r12 = $urandom_range(0, 1); s.r22 = $urandom_range(0, 1);
      end
      s.wv1 = ($urandom_range(0, 9) < 3); s.wt1 = rtag();
      s.wv2 = ($urandom_range(0, 9) < 3); s.wt2 = rtag();
      s.flush = ($urandom_range(0, 49) == 0);
      cycle(s);
    end
    cycle(idle(1));

    for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
Issue-side companion of the reservation-station allocator. It tracks per-entry busy and operand-ready state and takes up to two allocations per cycle from the allocator's free-entry outputs. It snoops two writeback tag broadcasts to wake operands, then picks one fully ready entry per cycle and presents it to the execution unit over a valid/ready handshake. Its busy vector feeds the allocator's busy input, which closes the allocate/free loop.

Parameters:
ENTRY_NUM, 4, number of reservation-station entries
ENTRY_SEL, 2, entry index width (log2 ENTRY_NUM)
TAG_LEN, 6, physical/ROB tag width for source operands

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; clears all entries
alloc_we1_i  in  1  write allocation slot 1
alloc_entry1_i  in  ENTRY_SEL  entry index for slot 1
alloc_src1_tag1_i / alloc_src2_tag1_i  in  TAG_LEN each  source tags, slot 1
alloc_src1_rdy1_i / alloc_src2_rdy1_i  in  1 each  source already ready, slot 1
alloc_we2_i, alloc_entry2_i, alloc_src1_tag2_i, alloc_src2_tag2_i, alloc_src1_rdy2_i, alloc_src2_rdy2_i  in  as slot 1  allocation slot 2
wb_valid1_i / wb_valid2_i  in  1 each  writeback broadcast valid
wb_tag1_i / wb_tag2_i  in  TAG_LEN each  writeback broadcast tag
busy_o  out  ENTRY_NUM  registered busy vector (to allocator busy input)
issue_valid_o  out  1  issue request valid
issue_ready_i  in  1  execution unit accepts
issue_entry_o  out  ENTRY_SEL  entry index being issued

Behaviour:
- Reset (async, rst_n_i=0): all busy, src-ready and issuing bits = 0; tags = 0; busy_o=0, issue_valid_o=0, issue_entry_o=0.
- Per-entry state: busy, issuing, src1_rdy, src2_rdy, src1_tag, src2_tag.
- Allocation at edge N (alloc_weK_i=1): busy=1, issuing=0, tags written.
  - srcX_rdy = alloc_srcX_rdyK_i OR (wb_valid1_i AND tag==wb_tag1_i) OR (wb_valid2_i AND tag==wb_tag2_i). This is a same-cycle wakeup bypass.
  - busy_o shows the new entry from N+1.
- Wakeup: every busy entry with a non-ready source whose tag equals a valid broadcast tag sets that ready bit at the edge.
- Eligible entry: busy AND src1_rdy AND src2_rdy AND NOT issuing. This uses registered state, so an entry allocated at edge N is eligible at N+1 at the earliest.
- Select: the lowest-index eligible entry wins (fixed priority).
- Output register: at each edge, if issue_valid_o=0 or issue_ready_i=1, the register loads the selected entry. issue_valid_o = (an eligible entry exists); the chosen entry's issuing bit is set.
  - Minimum alloc-to-issue_valid_o latency is 2 cycles: allocate with both sources ready at edge N, eligible from N+1, issue_valid_o asserted after edge N+1.
- Handshake: issue_valid_o AND issue_ready_i at an edge clears that entry's busy and issuing bits. busy_o drops at the next cycle. The replacement selection loads at the same edge, back to back at 1 issue per cycle.
- Stall: while issue_valid_o=1 and issue_ready_i=0, issue_entry_o and issue_valid_o hold stable. Other entries keep waking.
- Freed entries are invisible to the allocator until busy_o updates, so allocation and free never target the same entry in one cycle.
- Flush: flush_i=1 at an edge clears all busy, issuing and ready bits and deasserts issue_valid_o. Flush takes priority over simultaneous allocation, wakeup and handshake.
- Illegal (assert in simulation; RTL behaviour unspecified):
  - allocating an already-busy entry;
  - both slots writing the same entry;
  - alloc_we2_i=1 with alloc_we1_i=0 is legal.
- Widths: tag compares are exact TAG_LEN equality. ENTRY_NUM must equal 2**ENTRY_SEL.

Decomposition:
- Shared package: TAG_LEN and ENTRY_NUM/ENTRY_SEL constants, plus a per-entry status struct (busy, issuing, rdy bits, tags).
- One natural sub-module, rs_wakeup_cmp: per-source-operand tag compare against both broadcast ports, producing the wake bit. It is instanced 2×ENTRY_NUM times and also used by the allocation bypass path.

Test Plan:
1. Reset → allocate entry 0 with both sources ready at edge 1 → busy_o=4'b0001 after edge 1; issue_valid_o=1, issue_entry_o=0 after edge 2; with issue_ready_i=1, busy_o=0 after edge 3.
2. Allocate entries 1 and 2 in one cycle, src1_tag=5 not ready; wb_valid1_i=1, wb_tag1_i=5 two cycles later → both become eligible; entry 1 issues first, then entry 2 on the next cycle.
3. Allocate entry 3 with src2_tag=9 not ready while wb_tag2_i=9 is valid in the same cycle → bypass sets ready; issue_valid_o with issue_entry_o=3 two cycles later.
4. Entries 0 and 1 ready, issue_ready_i=0 for 3 cycles → issue_entry_o holds 0 and issue_valid_o holds 1; entry 1 is not issued. Release → entry 0 accepted, then entry 1 issues the following cycle.
5. All 4 entries busy with issue_valid_o=1; assert flush_i together with issue_ready_i and an allocation → after the edge, busy_o=0 and issue_valid_o=0.
6. Assert rst_n_i=0 asynchronously mid-stall → busy_o, issue_valid_o and issue_entry_o all read 0 immediately, without waiting for a clock edge.
